// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the decode read ports and the writeback register file.
// The master side drives the W-stage and decode inputs; the slave side is the register file.
interface wb_regfile_if #(
   parameter int DW = 32
);
   logic          regwritew;
   logic          memtoregw;
   logic          jumplinkw;
   logic [DW-1:0] rdw;
   logic [DW-1:0] aluoutw;
   logic [DW-1:0] pcplus4w;
   logic [4:0]    writeregw;
   logic [4:0]    ra1;
   logic [4:0]    ra2;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   logic [DW-1:0] resultw;
   logic [4:0]    wa_eff;
   logic          we_eff;
   logic [31:0]   commit_cnt;

   modport master (
      output regwritew, memtoregw, jumplinkw, rdw, aluoutw, pcplus4w, writeregw, ra1, ra2,
      input  rd1, rd2, resultw, wa_eff, we_eff, commit_cnt
   );

   modport slave (
      input  regwritew, memtoregw, jumplinkw, rdw, aluoutw, pcplus4w, writeregw, ra1, ra2,
      output rd1, rd2, resultw, wa_eff, we_eff, commit_cnt
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it into the MIPS register file and serves
// two combinational decode read ports with same-cycle write-through bypass.
module wb_regfile #(
   parameter int NREG     = 32,
   parameter int LINK_REG = 31,
   parameter int DW       = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_regfile_if.slave  bus
);

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic [31:0]   commit_cnt_q;
   logic [31:0]   commit_cnt_d;

   logic [DW-1:0] result;
   logic [4:0]    wa;
   logic          we;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;

   // Link instructions override both the result source and the destination register.
   always_comb begin
      result = bus.memtoregw ? bus.rdw : bus.aluoutw;
      wa     = bus.writeregw;
      if (bus.jumplinkw) begin
         result = bus.pcplus4w;
         wa     = 5'(LINK_REG);
      end
      we = rst_n & bus.regwritew & (wa != 5'd0);
   end

   always_comb begin
      regs_d       = regs_q;
      commit_cnt_d = commit_cnt_q;
      if (we) begin
         regs_d[wa]   = result;
         commit_cnt_d = commit_cnt_q + 32'd1;
      end
   end

   // Bypass lets decode observe the value committed on this same edge; it is off during reset.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (bus.ra1 != 5'd0) begin
         if (we && (bus.ra1 == wa)) begin
            rd1 = result;
         end else begin
            rd1 = regs_q[bus.ra1];
         end
      end
      if (bus.ra2 != 5'd0) begin
         if (we && (bus.ra2 == wa)) begin
            rd2 = result;
         end else begin
            rd2 = regs_q[bus.ra2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         commit_cnt_q <= '0;
      end else begin
         regs_q       <= regs_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   assign bus.resultw    = result;
   assign bus.wa_eff     = wa;
   assign bus.we_eff     = we;
   assign bus.rd1        = rd1;
   assign bus.rd2        = rd2;
   assign bus.commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset/wrap sequences,
// then randomized traffic against an array-based reference model.
module tb_wb_regfile;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   wb_regfile_if #(.DW(32)) bus ();

   wb_regfile #(.NREG(32), .LINK_REG(31), .DW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        regwritew;
      logic        memtoregw;
      logic        jumplinkw;
      logic [31:0] rdw;
      logic [31:0] aluoutw;
      logic [31:0] pcplus4w;
      logic [4:0]  writeregw;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp_rd1;
      logic [31:0] exp_rd2;
      logic [31:0] exp_res;
      logic [4:0]  exp_wa;
      logic        exp_we;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs [10];

   logic [31:0] model_regs [32];
   logic [31:0] model_cnt;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic we, input logic mem, input logic jl,
                                 input logic [31:0] rdw, input logic [31:0] alu,
                                 input logic [31:0] pc, input logic [4:0] wr,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
      bus.regwritew = we;
      bus.memtoregw = mem;
      bus.jumplinkw = jl;
      bus.rdw       = rdw;
      bus.aluoutw   = alu;
      bus.pcplus4w  = pc;
      bus.writeregw = wr;
      bus.ra1       = ra1;
      bus.ra2       = ra2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

      vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        5'd0, 5'd5,  5'd31,
                  32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 32'd0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h12345678, 32'h0,        5'd8, 5'd8,  5'd0,
                  32'h12345678, 32'h0,        32'h12345678, 5'd8,  1'b1, 32'd1};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        5'd0, 5'd8,  5'd8,
                  32'h12345678, 32'h12345678, 32'h0,        5'd0,  1'b0, 32'd1};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h11111111, 32'h0,        5'd9, 5'd9,  5'd8,
                  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 5'd9,  1'b1, 32'd2};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0,        32'h00400010, 5'd4, 5'd31, 5'd4,
                  32'h00400010, 32'h0,        32'h00400010, 5'd31, 1'b1, 32'd3};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        5'd0, 5'd31, 5'd4,
                  32'h00400010, 32'h0,        32'h0,        5'd0,  1'b0, 32'd3};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h0,        5'd0, 5'd0,  5'd9,
                  32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 5'd0,  1'b0, 32'd3};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hAAAA0001, 32'h0,        5'd8, 5'd8,  5'd8,
                  32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 5'd8,  1'b1, 32'd4};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBBBB0002, 32'h0,        5'd8, 5'd8,  5'd9,
                  32'hBBBB0002, 32'hDEADBEEF, 32'hBBBB0002, 5'd8,  1'b1, 32'd5};
      vecs[9] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'hCAFE0000, 5'd5, 5'd8,  5'd31,
                  32'hBBBB0002, 32'h00400010, 32'hCAFE0000, 5'd31, 1'b0, 32'd5};

      do_reset();

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         apply_stimulus(vecs[i].regwritew, vecs[i].memtoregw, vecs[i].jumplinkw, vecs[i].rdw,
                        vecs[i].aluoutw, vecs[i].pcplus4w, vecs[i].writeregw, vecs[i].ra1, vecs[i].ra2);
         #1;
         check_output($sformatf("vec%0d_rd1", i), bus.rd1, vecs[i].exp_rd1);
         check_output($sformatf("vec%0d_rd2", i), bus.rd2, vecs[i].exp_rd2);
         check_output($sformatf("vec%0d_resultw", i), bus.resultw, vecs[i].exp_res);
         check_output($sformatf("vec%0d_wa_eff", i), 32'(bus.wa_eff), 32'(vecs[i].exp_wa));
         check_output($sformatf("vec%0d_we_eff", i), 32'(bus.we_eff), 32'(vecs[i].exp_we));
         @(posedge clk);
         #1;
         check_output($sformatf("vec%0d_commit_cnt", i), bus.commit_cnt, vecs[i].exp_cnt);
      end

      // Reset arriving together with a pending write must drop it and suppress bypass.
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5A5A5, 32'h0, 5'd3, 5'd0, 5'd0);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
      #1;
      check_output("mid_rst_pre_read", bus.rd1, 32'hA5A5A5A5);
      check_output("mid_rst_pre_cnt", bus.commit_cnt, 32'd6);
      @(negedge clk);
      rst_n = 1'b0;
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h00000001, 32'h0, 5'd3, 5'd3, 5'd3);
      #1;
      check_output("mid_rst_no_bypass", bus.rd1, 32'hA5A5A5A5);
      check_output("mid_rst_we_eff", 32'(bus.we_eff), 32'd0);
      check_output("mid_rst_resultw", bus.resultw, 32'h00000001);
      @(posedge clk);
      #1;
      check_output("mid_rst_reg3_cleared", bus.rd2, 32'h0);
      check_output("mid_rst_cnt", bus.commit_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h00000077, 32'h0, 5'd3, 5'd3, 5'd0);
      @(posedge clk);
      #1;
      check_output("post_rst_first_write_cnt", bus.commit_cnt, 32'd1);
      check_output("post_rst_first_write_reg3", bus.rd1, 32'h00000077);

      // Counter wrap: preload the count to all-ones, then one valid write.
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
      force dut.commit_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.commit_cnt_q;
      #1;
      check_output("wrap_preload", bus.commit_cnt, 32'hFFFFFFFF);
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h00C0FFEE, 32'h0, 5'd7, 5'd7, 5'd0);
      @(posedge clk);
      #1;
      check_output("wrap_cnt_zero", bus.commit_cnt, 32'h0);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
      #1;
      check_output("wrap_reg7", bus.rd1, 32'h00C0FFEE);

      // Randomized traffic against the reference model.
      do_reset();
      for (int r = 0; r < 32; r++) model_regs[r] = 32'h0;
      model_cnt = 32'h0;
      for (int n = 0; n < 400; n++) begin
         logic        m_we, m_mem, m_jl, m_rst, e_we;
         logic [31:0] m_rdw, m_alu, m_pc, e_res, e_rd1, e_rd2;
         logic [4:0]  m_wr, m_ra1, m_ra2, e_wa;
         @(negedge clk);
         m_rst = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
         m_we  = ($urandom_range(0, 3) != 0);
         m_mem = $urandom_range(0, 1) == 1;
         m_jl  = ($urandom_range(0, 7) == 0);
         m_rdw = $urandom;
         m_alu = $urandom;
         m_pc  = $urandom;
         m_wr  = 5'($urandom_range(0, 7));
         m_ra1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         m_ra2 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         rst_n = m_rst;
         apply_stimulus(m_we, m_mem, m_jl, m_rdw, m_alu, m_pc, m_wr, m_ra1, m_ra2);

         if (m_jl)       e_res = m_pc;
         else if (m_mem) e_res = m_rdw;
         else            e_res = m_alu;
         e_wa  = m_jl ? 5'd31 : m_wr;
         e_we  = m_rst && m_we && (e_wa != 5'd0);
         e_rd1 = (m_ra1 == 5'd0) ? 32'h0 : ((e_we && m_ra1 == e_wa) ? e_res : model_regs[m_ra1]);
         e_rd2 = (m_ra2 == 5'd0) ? 32'h0 : ((e_we && m_ra2 == e_wa) ? e_res : model_regs[m_ra2]);

         #1;
         check_output("rand_rd1", bus.rd1, e_rd1);
         check_output("rand_rd2", bus.rd2, e_rd2);
         check_output("rand_resultw", bus.resultw, e_res);
         check_output("rand_wa_eff", 32'(bus.wa_eff), 32'(e_wa));
         check_output("rand_we_eff", 32'(bus.we_eff), 32'(e_we));
         check_output("rand_commit_cnt", bus.commit_cnt, model_cnt);

         if (!m_rst) begin
            for (int r = 0; r < 32; r++) model_regs[r] = 32'h0;
            model_cnt = 32'h0;
         end else if (e_we) begin
            model_regs[e_wa] = e_res;
            model_cnt        = model_cnt + 32'd1;
         end
         @(posedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline outputs.
- Selects the writeback result from ALU output, load data or the link address. Commits that result into a 32x32 MIPS general register file.
- Serves two combinational decode-stage read ports with same-cycle write-through bypass. Keeps a count of committed register writes for the performance/debug bench.

Parameters:
- NREG, 32, number of architectural registers (address width fixed at 5).
- LINK_REG, 31, destination register forced when jumplinkw is set.
- DW, 32, data width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- regwritew  in  1  W-stage register write enable.
- memtoregw  in  1  select load data (1) or ALU result (0).
- jumplinkw  in  1  link instruction (jal/jalr); overrides other result selects.
- rdw  in  DW  load data from the MEM/WB register.
- aluoutw  in  DW  ALU result from the MEM/WB register.
- pcplus4w  in  DW  return address from the MEM/WB register.
- writeregw  in  5  destination register from the MEM/WB register.
- ra1  in  5  decode read address 1.
- ra2  in  5  decode read address 2.
- rd1  out  DW  read data 1.
- rd2  out  DW  read data 2.
- resultw  out  DW  selected writeback value, for the forwarding network.
- wa_eff  out  5  effective write address (LINK_REG when jumplinkw, else writeregw).
- we_eff  out  1  effective write enable (see Behaviour).
- commit_cnt  out  32  number of committed register writes.

Behaviour:
- Reset: synchronous, active-low. On a rising clk edge with rst_n=0:
  - all NREG registers clear to 0;
  - commit_cnt clears to 0;
  - no write is performed, regardless of regwritew.
  - Reset asserted mid-stream discards the pending W-stage write. First write after reset can land on the first edge with rst_n=1.
- Result select (combinational):
  - resultw = jumplinkw ? pcplus4w : (memtoregw ? rdw : aluoutw).
  - jumplinkw has priority over memtoregw.
- Effective write address: wa_eff = jumplinkw ? LINK_REG : writeregw.
- Effective write enable: we_eff = rst_n & regwritew & (wa_eff != 0). Register 0 is never written.
- Write: on a rising clk edge with we_eff=1, reg[wa_eff] <= resultw. Write latency is one edge.
- commit_cnt increments by 1 on each edge with we_eff=1.
  - Wraps from 0xFFFFFFFF to 0 without saturation.
  - Attempted writes to $0 do not count.
- Reads: combinational.
  - rdN = 0 if raN==0.
  - Else, if we_eff=1 and raN==wa_eff, rdN = resultw (write-through bypass, so the same-cycle decode read sees the value being committed).
  - Else rdN = reg[raN].
  - Both ports may hit the same address or bypass simultaneously.
- Read during reset (rst_n=0): bypass is disabled; ports return stored contents.
- No X propagation: all registers are defined after the first reset edge. Behaviour before the first reset is undefined; the bench must reset first.
- Back-to-back writes to the same register: the last one wins. A read in the second cycle bypasses the second value.

Test Plan:
- Reset then read: hold rst_n=0 for 2 edges, release; ra1=5, ra2=31 -> rd1=0, rd2=0, commit_cnt=0.
- ALU write with bypass: regwritew=1, memtoregw=0, writeregw=8, aluoutw=0x1234_5678, ra1=8 in the same cycle -> rd1=0x12345678 before the edge, reg8 holds it after the edge, commit_cnt=1.
- Load vs link priority:
  - memtoregw=1, rdw=0xDEADBEEF, writeregw=9 -> reg9=0xDEADBEEF.
  - Then jumplinkw=1, memtoregw=1, pcplus4w=0x0040_0010, writeregw=4 -> reg31=0x00400010, reg4 unchanged, wa_eff=31.
- $0 protection: regwritew=1, writeregw=0, aluoutw=0xFFFF_FFFF -> we_eff=0, rd1(ra1=0)=0, commit_cnt unchanged.
- Reset mid-operation: write reg3=0xA5A5A5A5, then assert rst_n=0 on the same edge as regwritew=1 to reg3 with 0x1 -> reg3=0, no bypass while rst_n=0, commit_cnt=0.
- Counter wrap: preload commit_cnt via 2^32-1 writes (or force in bench), one more valid write -> commit_cnt=0.
